// File: rtl/alu_op_sequencer.sv
// Issue/writeback sequencer feeding a combinational ALU: accept, drive, write back.
// Optional `ALU_SEQ_OVERLAP_EN lets a new op be accepted during writeback (1 op / 2 cycles).
module alu_op_sequencer #(
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [WIDTH-1:0]  req_a,
  input  logic [WIDTH-1:0]  req_b,
  input  logic [ADDR_W-1:0] req_dst,
  output logic [WIDTH-1:0]  alu_r0_rd,
  output logic [WIDTH-1:0]  alu_rs,
  output logic [1:0]        alu_control,
  input  logic [WIDTH-1:0]  alu_result,
  input  logic              alu_z,
  output logic              wb_en,
  output logic [ADDR_W-1:0] wb_addr,
  output logic [WIDTH-1:0]  wb_data,
  output logic              z_flag,
  output logic [7:0]        op_count,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, DRIVE, WB} state_t;

  state_t            state;
  logic [ADDR_W-1:0] dst_q;

  // Handshake and status are pure decodes of the state register, never of req_valid.
`ifdef ALU_SEQ_OVERLAP_EN
  assign req_ready = (state == IDLE) || (state == WB);
`else
  assign req_ready = (state == IDLE);
`endif
  assign busy  = (state != IDLE);
  assign wb_en = (state == WB);

  // wb_addr is loaded from dst_q at DRIVE so an overlapped accept cannot disturb the
  // writeback that is still in progress.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      alu_r0_rd   <= '0;
      alu_rs      <= '0;
      alu_control <= '0;
      dst_q       <= '0;
      wb_addr     <= '0;
      wb_data     <= '0;
      z_flag      <= 1'b0;
      op_count    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            alu_r0_rd   <= req_a;
            alu_rs      <= req_b;
            alu_control <= req_op;
            dst_q       <= req_dst;
            state       <= DRIVE;
          end
        end
        DRIVE: begin
          wb_data <= alu_result;
          z_flag  <= alu_z;
          wb_addr <= dst_q;
          state   <= WB;
        end
        WB: begin
          op_count <= op_count + 8'd1;
`ifdef ALU_SEQ_OVERLAP_EN
          if (req_valid) begin
            alu_r0_rd   <= req_a;
            alu_rs      <= req_b;
            alu_control <= req_op;
            dst_q       <= req_dst;
            state       <= DRIVE;
          end else begin
            state <= IDLE;
          end
`else
          state <= IDLE;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed self-checking bench for alu_op_sequencer with a behavioural ALU stub.
// Spacing expectations follow `ALU_SEQ_OVERLAP_EN when it is defined.
module tb_alu_op_sequencer;

  localparam int WIDTH  = 8;
  localparam int ADDR_W = 3;
`ifdef ALU_SEQ_OVERLAP_EN
  localparam int    SPACING  = 2;
  localparam logic  WB_READY = 1'b1;
`else
  localparam int    SPACING  = 3;
  localparam logic  WB_READY = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset;
  logic              req_valid;
  logic              req_ready;
  logic [1:0]        req_op;
  logic [WIDTH-1:0]  req_a, req_b;
  logic [ADDR_W-1:0] req_dst;
  logic [WIDTH-1:0]  alu_r0_rd, alu_rs, alu_result, wb_data;
  logic [1:0]        alu_control;
  logic              alu_z, wb_en, z_flag, busy;
  logic [ADDR_W-1:0] wb_addr;
  logic [7:0]        op_count;

  int vectors = 0;
  int errors  = 0;
  int cyc_count = 0;
  int acc_cyc[$];
  int wb_cyc[$];
  logic [WIDTH-1:0] wb_q[$];

  alu_op_sequencer #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_dst(req_dst),
    .alu_r0_rd(alu_r0_rd), .alu_rs(alu_rs), .alu_control(alu_control),
    .alu_result(alu_result), .alu_z(alu_z),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .z_flag(z_flag), .op_count(op_count), .busy(busy)
  );

  always #5 clk = ~clk;

  // ALU stub: 0 add, 1 sub, 2 and, 3 or.
  always_comb begin
    alu_result = '0;
    case (alu_control)
      2'd0: alu_result = alu_r0_rd + alu_rs;
      2'd1: alu_result = alu_r0_rd - alu_rs;
      2'd2: alu_result = alu_r0_rd & alu_rs;
      default: alu_result = alu_r0_rd | alu_rs;
    endcase
    alu_z = (alu_result == '0);
  end

  always @(posedge clk) cyc_count <= cyc_count + 1;

  always @(negedge clk) begin
    if (req_valid && req_ready) acc_cyc.push_back(cyc_count);
    if (wb_en) begin
      wb_cyc.push_back(cyc_count);
      wb_q.push_back(wb_data);
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Presents one request and returns #1 after the accepting edge (state DRIVE).
  task automatic apply_stimulus(input logic [1:0] op, input logic [WIDTH-1:0] a,
                                input logic [WIDTH-1:0] b, input logic [ADDR_W-1:0] dst);
    req_op = op; req_a = a; req_b = b; req_dst = dst; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  initial begin
    logic [1:0]       b_op[3];
    logic [WIDTH-1:0] b_a[3];
    logic [WIDTH-1:0] b_b[3];
    int n;
    int wb_before;

    reset = 1'b1; req_valid = 1'b0; req_op = '0; req_a = '0; req_b = '0; req_dst = '0;
    repeat (2) @(posedge clk);
    #1;
    check_output("rst_ready", req_ready, 1);
    check_output("rst_busy", busy, 0);
    check_output("rst_wb_en", wb_en, 0);
    check_output("rst_r0_rd", alu_r0_rd, 0);
    check_output("rst_rs", alu_rs, 0);
    check_output("rst_control", alu_control, 0);
    check_output("rst_wb_addr", wb_addr, 0);
    check_output("rst_wb_data", wb_data, 0);
    check_output("rst_z_flag", z_flag, 0);
    check_output("rst_op_count", op_count, 0);
    reset = 1'b0;
    step();

    // Single op, then scramble the request inputs to confirm operand hold
    apply_stimulus(2'd0, 8'd3, 8'd3, 3'd5);
    req_a = 8'hAA; req_b = 8'h55; req_op = 2'd3;
    check_output("drv_r0_rd", alu_r0_rd, 3);
    check_output("drv_rs", alu_rs, 3);
    check_output("drv_control", alu_control, 0);
    check_output("drv_ready", req_ready, 0);
    check_output("drv_busy", busy, 1);
    check_output("drv_wb_en", wb_en, 0);
    step();
    check_output("wb_en", wb_en, 1);
    check_output("wb_addr", wb_addr, 5);
    check_output("wb_data", wb_data, 8'h06);
    check_output("wb_z_flag", z_flag, 0);
    check_output("wb_ready", req_ready, WB_READY);
    check_output("hold_r0_rd", alu_r0_rd, 3);
    check_output("hold_rs", alu_rs, 3);
    step();
    check_output("idle_wb_en", wb_en, 0);
    check_output("idle_op_count", op_count, 1);
    check_output("idle_ready", req_ready, 1);
    check_output("idle_busy", busy, 0);
    check_output("idle_wb_data", wb_data, 8'h06);
    check_output("idle_wb_addr", wb_addr, 5);
    check_output("idle_r0_rd", alu_r0_rd, 3);

    // Zero flag sets and stays sticky through idle, then clears on a nonzero result
    apply_stimulus(2'd1, 8'd3, 8'd3, 3'd2);
    step();
    check_output("z_wb_z_flag", z_flag, 1);
    check_output("z_wb_data", wb_data, 8'h00);
    check_output("z_wb_addr", wb_addr, 2);
    repeat (3) step();
    check_output("z_sticky", z_flag, 1);
    check_output("z_op_count", op_count, 2);
    apply_stimulus(2'd0, 8'd1, 8'd2, 3'd7);
    step();
    check_output("z_clear", z_flag, 0);
    check_output("z_clear_data", wb_data, 8'h03);
    step();
    check_output("z_clear_count", op_count, 3);

    // Back-to-back with req_valid held high
    b_op[0] = 2'd0; b_a[0] = 8'd10;  b_b[0] = 8'd5;
    b_op[1] = 2'd1; b_a[1] = 8'd10;  b_b[1] = 8'd5;
    b_op[2] = 2'd2; b_a[2] = 8'hF0;  b_b[2] = 8'h3C;
    acc_cyc.delete(); wb_cyc.delete(); wb_q.delete();
    req_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      req_op = b_op[k]; req_a = b_a[k]; req_b = b_b[k]; req_dst = 3'(k);
      n = 0;
      while (!req_ready && n < 10) begin
        step();
        n++;
      end
      check_output("b2b_ready_wait", (n < 10), 1);
      step();
    end
    req_valid = 1'b0;
    repeat (4) step();
    check_output("b2b_accepts", acc_cyc.size(), 3);
    check_output("b2b_wb_count", wb_cyc.size(), 3);
    if (acc_cyc.size() == 3 && wb_cyc.size() == 3) begin
      check_output("b2b_acc_gap0", acc_cyc[1] - acc_cyc[0], SPACING);
      check_output("b2b_acc_gap1", acc_cyc[2] - acc_cyc[1], SPACING);
      check_output("b2b_wb_gap0", wb_cyc[1] - wb_cyc[0], SPACING);
      check_output("b2b_wb_gap1", wb_cyc[2] - wb_cyc[1], SPACING);
      check_output("b2b_latency", wb_cyc[0] - acc_cyc[0], 2);
      check_output("b2b_data0", wb_q[0], 8'h0F);
      check_output("b2b_data1", wb_q[1], 8'h05);
      check_output("b2b_data2", wb_q[2], 8'h30);
    end
    check_output("b2b_op_count", op_count, 6);

    // Reset while in DRIVE discards the op
    wb_before = wb_cyc.size();
    apply_stimulus(2'd0, 8'd9, 8'd9, 3'd4);
    reset = 1'b1;
    step();
    check_output("mid_rst_wb_en", wb_en, 0);
    check_output("mid_rst_busy", busy, 0);
    check_output("mid_rst_ready", req_ready, 1);
    check_output("mid_rst_r0_rd", alu_r0_rd, 0);
    check_output("mid_rst_wb_data", wb_data, 0);
    check_output("mid_rst_op_count", op_count, 0);
    reset = 1'b0;
    repeat (3) step();
    check_output("mid_rst_no_wb", wb_cyc.size() - wb_before, 0);
    check_output("mid_rst_count_hold", op_count, 0);

    // Counter wrap after 256 completed ops; the last op also exercises FF+1 -> 0
    for (int i = 0; i < 255; i++) begin
      apply_stimulus(2'd0, 8'(i), 8'd1, 3'(i));
      step();
      step();
    end
    check_output("wrap_255", op_count, 255);
    apply_stimulus(2'd0, 8'hFF, 8'd1, 3'd6);
    step();
    check_output("wrap_wb_en", wb_en, 1);
    check_output("wrap_pre", op_count, 255);
    check_output("wrap_wb_data", wb_data, 8'h00);
    check_output("wrap_z_flag", z_flag, 1);
    step();
    check_output("wrap_zero", op_count, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
